// File: rtl/elev_sched_ctrl.sv
// elev_sched_ctrl: N-floor SCAN elevator controller with internal run/door timers.
// Optional door-hold feature enabled by defining ELEV_DOOR_HOLD_EN.
module elev_sched_ctrl #(
  parameter int FLOORS     = 4,
  parameter int RUN_TICKS  = 32,
  parameter int OPEN_TICKS = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      switch,
  input  logic [FLOORS-1:0]         req,
  input  logic                      door_hold,
  output logic [FLOORS-1:0]         position,
  output logic [$clog2(FLOORS)-1:0] floor_idx,
  output logic [1:0]                ud_mode,
  output logic [2:0]                state,
  output logic                      opendoor,
  output logic                      mv2nxt,
  output logic [FLOORS-1:0]         req_clear
);
  localparam int IW = $clog2(FLOORS);
  localparam int TW = $clog2((RUN_TICKS > OPEN_TICKS ? RUN_TICKS : OPEN_TICKS) + 1);
  localparam logic [FLOORS-1:0] ONE = FLOORS'(1);
  localparam logic [1:0] IDLE = 2'b00, UP = 2'b01, DN = 2'b10;
  typedef enum logic [2:0] {STOP = 3'd0, PAUSE = 3'd1, MOVE = 3'd2, OPEN = 3'd3} state_t;
  state_t            st_q, st_d;
  logic [FLOORS-1:0] pos_q, pos_d, rclr_q, rclr_d, pos_up;
  logic [IW-1:0]     idx_q, idx_d;
  logic [1:0]        ud_q, ud_d;
  logic              door_q, door_d, mv_q, mv_d;
  logic [TW-1:0]     run_q, run_d, dt_q, dt_d;
  logic              up_need, dn_need, up_ok, dn_ok, hold;
`ifdef ELEV_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  logic unused_door_hold;
  assign unused_door_hold = door_hold;
  assign hold = 1'b0;
`endif
  // Masks strictly above / strictly below the one-hot position; top floor wraps pos_up to 0.
  assign pos_up  = pos_q << 1;
  assign up_need = |(req & ~(pos_up - ONE));
  assign dn_need = |(req & (pos_q - ONE));
  assign up_ok   = ud_q == UP && !pos_q[FLOORS-1];
  assign dn_ok   = ud_q == DN && !pos_q[0];
  always_comb begin
    st_d   = st_q;
    pos_d  = pos_q;
    idx_d  = idx_q;
    ud_d   = ud_q;
    door_d = door_q;
    mv_d   = mv_q;
    rclr_d = '0;
    run_d  = run_q;
    dt_d   = dt_q;
    case (st_q)
      STOP: st_d = PAUSE;
      PAUSE: begin
        if (|(req & pos_q)) begin
          st_d   = OPEN;
          door_d = 1'b1;
          rclr_d = pos_q;
          dt_d   = '0;
        end else if (up_need || dn_need) begin
          st_d  = MOVE;
          mv_d  = 1'b1;
          run_d = '0;
          ud_d  = ((ud_q == DN && dn_need) || !up_need) ? DN : UP;
        end else ud_d = IDLE;
      end
      MOVE: begin
        run_d = run_q + TW'(1);
        if (run_q == TW'(RUN_TICKS - 1)) begin
          st_d  = PAUSE;
          mv_d  = 1'b0;
          run_d = '0;
          pos_d = up_ok ? pos_q << 1 : dn_ok ? pos_q >> 1 : pos_q;
          idx_d = up_ok ? idx_q + IW'(1) : dn_ok ? idx_q - IW'(1) : idx_q;
        end
      end
      OPEN: begin
        dt_d   = hold ? '0 : dt_q + TW'(1);
        rclr_d = req & pos_q & ~rclr_q;
        if (!hold && dt_q == TW'(OPEN_TICKS - 1)) begin
          st_d   = PAUSE;
          door_d = 1'b0;
          dt_d   = '0;
        end
      end
      default: begin
        st_d   = STOP;
        pos_d  = ONE;
        idx_d  = '0;
        ud_d   = IDLE;
        door_d = 1'b0;
        mv_d   = 1'b0;
        run_d  = '0;
        dt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n || !switch) begin
      st_q   <= STOP;
      pos_q  <= ONE;
      idx_q  <= '0;
      ud_q   <= IDLE;
      door_q <= 1'b0;
      mv_q   <= 1'b0;
      rclr_q <= '0;
      run_q  <= '0;
      dt_q   <= '0;
    end else begin
      st_q   <= st_d;
      pos_q  <= pos_d;
      idx_q  <= idx_d;
      ud_q   <= ud_d;
      door_q <= door_d;
      mv_q   <= mv_d;
      rclr_q <= rclr_d;
      run_q  <= run_d;
      dt_q   <= dt_d;
    end
  end
  assign position  = pos_q;
  assign floor_idx = idx_q;
  assign ud_mode   = ud_q;
  assign state     = st_q;
  assign opendoor  = door_q;
  assign mv2nxt    = mv_q;
  assign req_clear = rclr_q;
endmodule

// File: tb/tb_elev_sched_ctrl.sv
// tb_elev_sched_ctrl: scoreboard bench for elev_sched_ctrl (4-floor and 8-floor instances).
module tb_elev_sched_ctrl;
  localparam int RT = 4;
  localparam int OT = 6;
  typedef struct {int idx; int ud;} ev_t;
  logic       clk = 1'b0;
  logic       rst_n, switch, door_hold;
  logic [3:0] req, position, req_clear;
  logic [1:0] floor_idx, ud_mode;
  logic [2:0] state;
  logic       opendoor, mv2nxt;
  logic [7:0] req8, position8, req_clear8;
  logic [2:0] floor_idx8, state8;
  logic [1:0] ud_mode8;
  logic       opendoor8, mv2nxt8;
  int         n_vec = 0, n_bad = 0, door_n = 0, mv_n = 0, exp_door = OT;
  ev_t        sb[$];
  always #5 clk = ~clk;
  elev_sched_ctrl #(.FLOORS(4), .RUN_TICKS(RT), .OPEN_TICKS(OT)) u_dut (
    .clk(clk), .rst_n(rst_n), .switch(switch), .req(req), .door_hold(door_hold),
    .position(position), .floor_idx(floor_idx), .ud_mode(ud_mode), .state(state),
    .opendoor(opendoor), .mv2nxt(mv2nxt), .req_clear(req_clear));
  elev_sched_ctrl #(.FLOORS(8), .RUN_TICKS(RT), .OPEN_TICKS(OT)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .switch(switch), .req(req8), .door_hold(1'b0),
    .position(position8), .floor_idx(floor_idx8), .ud_mode(ud_mode8), .state(state8),
    .opendoor(opendoor8), .mv2nxt(mv2nxt8), .req_clear(req_clear8));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // One clock: monitor at negedge, then request-register clear just after posedge.
  task automatic step();
    ev_t e;
    @(negedge clk);
    if (!rst_n || !switch) begin
      door_n = 0;
      mv_n = 0;
    end else begin
      if (opendoor) door_n++;
      else if (door_n != 0) begin
        chk("door_len", 32'(door_n), 32'(exp_door));
        door_n = 0;
      end
      if (mv2nxt) mv_n++;
      else if (mv_n != 0) begin
        chk("hop_len", 32'(mv_n), 32'(RT));
        mv_n = 0;
      end
    end
    if (req_clear != 4'd0) begin
      if (sb.size() == 0) chk("sb_extra", 32'(req_clear), 32'd0);
      else begin
        e = sb.pop_front();
        chk("srv_idx", 32'(floor_idx), 32'(e.idx));
        chk("srv_clr", 32'(req_clear), 32'd1 << e.idx);
        chk("srv_dir", 32'(ud_mode), 32'(e.ud));
      end
    end
    @(posedge clk);
    #1;
    req = req & ~req_clear;
    req8 = req8 & ~req_clear8;
  endtask
  function automatic bit cond(input int mode, input int val);
    case (mode)
      0: return state == 3'd1 && ud_mode == 2'b00 && req == 4'd0 && !opendoor;
      1: return int'(floor_idx) == val && state == 3'd1;
      2: return int'(floor_idx) == val && state == 3'd2;
      3: return opendoor;
      4: return state8 == 3'd1 && ud_mode8 == 2'b00 && req8 == 8'd0 && !opendoor8;
      default: return int'(floor_idx8) == val;
    endcase
  endfunction
  task automatic wait_for(input string tag, input int mode, input int val);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (cond(mode, val)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask
  task automatic push(input int idx, input int ud);
    ev_t e;
    e.idx = idx;
    e.ud = ud;
    sb.push_back(e);
  endtask
  initial begin
    rst_n = 1'b0; switch = 1'b1; door_hold = 1'b0; req = '0; req8 = '0;
    repeat (3) step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pos", 32'(position), 32'd1);
    chk("rst_idx", 32'(floor_idx), 32'd0);
    chk("rst_ud", 32'(ud_mode), 32'd0);
    chk("rst_door", 32'(opendoor), 32'd0);
    chk("rst_mv", 32'(mv2nxt), 32'd0);
    chk("rst_clr", 32'(req_clear), 32'd0);
    rst_n = 1'b1;
    step();
    chk("stop_to_pause", 32'(state), 32'd1);
    req = 4'b1000; push(3, 1);
    wait_for("idle_f3", 0, 0);
    chk("at_f3", 32'(floor_idx), 32'd3);
    chk("at_f3_pos", 32'(position), 32'b1000);
    req = 4'b0010; push(1, 2);
    wait_for("idle_f1", 0, 0);
    chk("at_f1", 32'(floor_idx), 32'd1);
    req = 4'b1001; push(3, 1); push(0, 2);
    step();
    chk("up_pref_st", 32'(state), 32'd2);
    chk("up_pref_ud", 32'(ud_mode), 32'd1);
    wait_for("idle_scan1", 0, 0);
    chk("scan1_end", 32'(floor_idx), 32'd0);
    req = 4'b1000; push(3, 1);
    wait_for("reach_f1", 1, 1);
    req = req | 4'b0001; push(0, 2);
    wait_for("idle_scan2", 0, 0);
    chk("scan2_end", 32'(floor_idx), 32'd0);
    req = 4'b0001; push(0, 0);
    wait_for("open_f0", 3, 0);
    repeat (2) step();
    req = req | 4'b0001; push(0, 0);
    wait_for("idle_reopen", 0, 0);
    req = 4'b0001; push(0, 0);
    wait_for("open_hold", 3, 0);
`ifdef ELEV_DOOR_HOLD_EN
    exp_door = 12 + OT;
`endif
    repeat (2) step();
    door_hold = 1'b1;
    repeat (10) step();
    door_hold = 1'b0;
    wait_for("idle_hold", 0, 0);
    exp_door = OT;
    req = 4'b1000; push(3, 1);
    wait_for("move_f2", 2, 2);
    rst_n = 1'b0;
    step();
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_pos", 32'(position), 32'b0001);
    chk("abort_mv", 32'(mv2nxt), 32'd0);
    chk("abort_ud", 32'(ud_mode), 32'd0);
    req = '0;
    sb.delete();
    step();
    rst_n = 1'b1;
    repeat (2) step();
    req = 4'b0001; push(0, 0);
    wait_for("open_sw", 3, 0);
    repeat (2) step();
    switch = 1'b0;
    step();
    chk("sw_door", 32'(opendoor), 32'd0);
    chk("sw_state", 32'(state), 32'd0);
    switch = 1'b1;
    repeat (2) step();
    chk("sw_resume", 32'(state), 32'd1);
    req8 = 8'h80;
    wait_for("f8_up", 4, 0);
    chk("f8_top_idx", 32'(floor_idx8), 32'd7);
    chk("f8_top_pos", 32'(position8), 32'h80);
    req8 = 8'h01;
    for (int k = 1; k <= 7; k++) begin
      wait_for("f8_hop", 5, 7 - k);
      chk("f8_pos", 32'(position8), 32'd1 << (7 - k));
    end
    wait_for("f8_down", 4, 0);
    chk("f8_bot_pos", 32'(position8), 32'h01);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
